// File: rtl/button_events_if.sv
// Event port between the button front end and the macro-sequencer.
// The master side produces button events; the slave side accepts them.
interface button_events_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [4:0]  ev_btn;
  logic [15:0] ev_sw;
  logic [7:0]  ev_drop_cnt;

  modport master (
    output ev_valid,
    output ev_btn,
    output ev_sw,
    output ev_drop_cnt,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_btn,
    input  ev_sw,
    input  ev_drop_cnt,
    output ev_ready
  );
endinterface

// File: rtl/button_events.sv
// Button front end: synchronises and debounces five buttons, queues one press per
// button and hands presses out one at a time with a switch snapshot.
module button_events #(
  parameter int DEBOUNCE_CYCLES = 1600000,
  parameter int CNT_W           = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   btn,
  input  logic [15:0]  sw,
  button_events_if.master ev
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Isolates the lowest set bit, which gives the C > U > L > R > D priority.
  function automatic logic [4:0] lowest_one(input logic [4:0] v);
    lowest_one = v & (~v + 5'd1);
  endfunction

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, v[i]};
    end
    popcount5 = n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {6'b000000, b};
    sat_add8 = sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [4:0]       btn_meta_r;
  logic [4:0]       btn_sync_r;
  logic [15:0]      sw_meta_r;
  logic [15:0]      sw_sync_r;
  logic [CNT_W-1:0] cnt_r      [5];
  logic [CNT_W-1:0] cnt_nxt_s  [5];
  logic [4:0]       stable_r;
  logic [4:0]       stable_nxt_s;
  logic [4:0]       stable_d_r;
  logic [4:0]       pending_r;
  logic [4:0]       pending_nxt_s;
  logic [4:0]       press_s;
  logic [4:0]       sel_s;
  logic [4:0]       clear_s;
  logic [4:0]       drop_s;
  logic             loadable_s;
  logic             load_s;
  logic             ev_valid_r;
  logic [4:0]       ev_btn_r;
  logic [15:0]      ev_sw_r;
  logic [7:0]       drop_cnt_r;

  // Two-flop synchronisers for the raw buttons and switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_r <= 5'b00000;
      btn_sync_r <= 5'b00000;
      sw_meta_r  <= 16'h0000;
      sw_sync_r  <= 16'h0000;
    end else begin
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Per-button debounce: any sample matching the accepted level restarts the count.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    stable_nxt_s = stable_r;
    for (int i = 0; i < 5; i++) begin
      if (btn_sync_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == DB_LAST) begin
        cnt_nxt_s[i]    = {CNT_W{1'b0}};
        stable_nxt_s[i] = ~stable_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Debounce state registers, plus a delayed copy for press edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      stable_r   <= 5'b00000;
      stable_d_r <= 5'b00000;
    end else begin
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      stable_r   <= stable_nxt_s;
      stable_d_r <= stable_r;
    end
  end

  // Pending queue update; a fresh press beats a same-cycle clear by load.
  always_comb begin
    press_s       = stable_r & ~stable_d_r;
    loadable_s    = ~ev_valid_r | ev.ev_ready;
    sel_s         = lowest_one(pending_r);
    load_s        = loadable_s & (pending_r != 5'b00000);
    if (load_s) begin
      clear_s = sel_s;
    end else begin
      clear_s = 5'b00000;
    end
    drop_s        = press_s & pending_r & ~clear_s;
    pending_nxt_s = (pending_r & ~clear_s) | press_s;
  end

  // Pending bits and the saturating overrun counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r  <= 5'b00000;
      drop_cnt_r <= 8'h00;
    end else begin
      pending_r  <= pending_nxt_s;
      drop_cnt_r <= sat_add8(drop_cnt_r, popcount5(drop_s));
    end
  end

  // Output event register; holds its contents while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid_r <= 1'b0;
      ev_btn_r   <= 5'b00000;
      ev_sw_r    <= 16'h0000;
    end else if (loadable_s) begin
      if (load_s) begin
        ev_valid_r <= 1'b1;
        ev_btn_r   <= sel_s;
        ev_sw_r    <= sw_sync_r;
      end else begin
        ev_valid_r <= 1'b0;
      end
    end
  end

  assign ev.ev_valid    = ev_valid_r;
  assign ev.ev_btn      = ev_btn_r;
  assign ev.ev_sw       = ev_sw_r;
  assign ev.ev_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with a debounce length of 4 cycles.
module tb_button_events;

  logic        clk;
  logic        rst;
  logic [4:0]  btn;
  logic [15:0] sw;
  int          checks;
  int          errors;

  button_events_if ev_if ();

  button_events #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .sw  (sw),
    .ev  (ev_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ev_if.ev_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle();
    btn = 5'b00000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 5'b00000;
    sw = 16'h0000;
    ev_if.ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ev_if.ev_valid); end
    checks++; if (ev_if.ev_btn !== 5'b00000) begin errors++; $display("FAIL reset_btn got=%b exp=00000", ev_if.ev_btn); end
    checks++; if (ev_if.ev_sw !== 16'h0000) begin errors++; $display("FAIL reset_sw got=%h exp=0000", ev_if.ev_sw); end
    checks++; if (ev_if.ev_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", ev_if.ev_drop_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int vcount;
    ev_if.ev_ready = 1'b1;
    sw = 16'hA5C3;
    btn = 5'b00100;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (ev_if.ev_valid !== (k == 7)) begin
        errors++; $display("FAIL single_valid edge=%0d got=%b exp=%b", k, ev_if.ev_valid, (k == 7));
      end
      if (k == 7) begin
        checks++; if (ev_if.ev_btn !== 5'b00100) begin errors++; $display("FAIL single_btn got=%b exp=00100", ev_if.ev_btn); end
        checks++; if (ev_if.ev_sw !== 16'hA5C3) begin errors++; $display("FAIL single_sw got=%h exp=a5c3", ev_if.ev_sw); end
      end
    end
    btn = 5'b00000;
    vcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (ev_if.ev_valid === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL single_release events=%0d exp=0", vcount); end
  endtask

  task automatic test_bounce();
    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int vcount;
    logic [4:0] seen_btn;
    ev_if.ev_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 9; i++) begin
      btn = {4'b0000, pat[i]};
      @(negedge clk);
      if (ev_if.ev_valid === 1'b1) vcount++;
    end
    btn = 5'b00000;
    repeat (10) begin
      @(negedge clk);
      if (ev_if.ev_valid === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL bounce_reject events=%0d exp=0", vcount); end
    vcount = 0;
    seen_btn = 5'b00000;
    btn = 5'b00001;
    repeat (6) begin
      @(negedge clk);
      if (ev_if.ev_valid === 1'b1) begin vcount++; seen_btn = ev_if.ev_btn; end
    end
    btn = 5'b00000;
    repeat (15) begin
      @(negedge clk);
      if (ev_if.ev_valid === 1'b1) begin vcount++; seen_btn = ev_if.ev_btn; end
    end
    checks++; if (vcount != 1) begin errors++; $display("FAIL bounce_hold events=%0d exp=1", vcount); end
    checks++; if (seen_btn !== 5'b00001) begin errors++; $display("FAIL bounce_btn got=%b exp=00001", seen_btn); end
  endtask

  task automatic test_priority();
    bit ok;
    int bad;
    ev_if.ev_ready = 1'b0;
    btn = 5'b11010;
    wait_valid(20, ok);
    btn = 5'b00000;
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout got=no_event exp=event"); end
    checks++; if (ev_if.ev_btn !== 5'b00010) begin errors++; $display("FAIL prio_first got=%b exp=00010", ev_if.ev_btn); end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_btn !== 5'b00010) begin
        errors++; $display("FAIL prio_hold valid=%b btn=%b exp=1/00010", ev_if.ev_valid, ev_if.ev_btn);
      end
    end
    ev_if.ev_ready = 1'b1;
    @(negedge clk);
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_btn !== 5'b01000) begin errors++; $display("FAIL prio_second valid=%b btn=%b exp=1/01000", ev_if.ev_valid, ev_if.ev_btn); end
    @(negedge clk);
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_btn !== 5'b10000) begin errors++; $display("FAIL prio_third valid=%b btn=%b exp=1/10000", ev_if.ev_valid, ev_if.ev_btn); end
    @(negedge clk);
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL prio_empty valid=%b exp=0", ev_if.ev_valid); end
  endtask

  task automatic test_overrun();
    int vcount;
    ev_if.ev_ready = 1'b0;
    repeat (3) begin
      btn = 5'b00001;
      repeat (8) @(negedge clk);
      btn = 5'b00000;
      repeat (8) @(negedge clk);
    end
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_btn !== 5'b00001) begin errors++; $display("FAIL overrun_head valid=%b btn=%b exp=1/00001", ev_if.ev_valid, ev_if.ev_btn); end
    checks++; if (ev_if.ev_drop_cnt !== 8'd1) begin errors++; $display("FAIL overrun_drop got=%0d exp=1", ev_if.ev_drop_cnt); end
    ev_if.ev_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (ev_if.ev_valid === 1'b1 && ev_if.ev_btn === 5'b00001) vcount++;
      @(negedge clk);
    end
    checks++; if (vcount != 2) begin errors++; $display("FAIL overrun_events got=%0d exp=2", vcount); end
  endtask

  task automatic test_snapshot();
    bit ok;
    ev_if.ev_ready = 1'b0;
    sw = 16'h0001;
    btn = 5'b00001;
    wait_valid(20, ok);
    btn = 5'b00000;
    checks++; if (!ok) begin errors++; $display("FAIL snap_timeout got=no_event exp=event"); end
    checks++; if (ev_if.ev_sw !== 16'h0001) begin errors++; $display("FAIL snap_load got=%h exp=0001", ev_if.ev_sw); end
    sw = 16'hFFFF;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_sw !== 16'h0001) begin
        errors++; $display("FAIL snap_hold valid=%b sw=%h exp=1/0001", ev_if.ev_valid, ev_if.ev_sw);
      end
    end
    ev_if.ev_ready = 1'b1;
    @(negedge clk);
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL snap_accept valid=%b exp=0", ev_if.ev_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ev_if.ev_ready = 1'b0;
    btn = 5'b00011;
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got=no_event exp=event"); end
    checks++; if (ev_if.ev_btn !== 5'b00001) begin errors++; $display("FAIL rstmid_pre got=%b exp=00001", ev_if.ev_btn); end
    @(negedge clk);
    rst = 1'b1;
    btn = 5'b00001;
    @(negedge clk);
    rst = 1'b0;
    ev_if.ev_ready = 1'b1;
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", ev_if.ev_valid); end
    checks++; if (ev_if.ev_btn !== 5'b00000) begin errors++; $display("FAIL rstmid_btn got=%b exp=00000", ev_if.ev_btn); end
    checks++; if (ev_if.ev_sw !== 16'h0000) begin errors++; $display("FAIL rstmid_sw got=%h exp=0000", ev_if.ev_sw); end
    checks++; if (ev_if.ev_drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_drop got=%0d exp=0", ev_if.ev_drop_cnt); end
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (ev_if.ev_valid !== (k == 7)) begin
        errors++; $display("FAIL rstmid_event edge=%0d got=%b exp=%b", k, ev_if.ev_valid, (k == 7));
      end
      if (k == 7) begin
        checks++; if (ev_if.ev_btn !== 5'b00001) begin errors++; $display("FAIL rstmid_evbtn got=%b exp=00001", ev_if.ev_btn); end
      end
    end
    btn = 5'b00000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    btn = 5'b00000;
    sw = 16'h0000;
    ev_if.ev_ready = 1'b0;
    test_reset();
    test_single();
    idle();
    test_bounce();
    idle();
    test_priority();
    idle();
    test_overrun();
    idle();
    test_snapshot();
    idle();
    test_reset_mid();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
